spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
- Parametrised SPI master; next generation of the split ctrl/inst SPI master pair, merged into one block.
- Adds multi-word transfers, a programmable SCLK divider, runtime CPOL/CPHA mode, NSS slave selects, an abort input and a start/busy/done handshake.
- Sits between a register-level host interface and external SPI slaves.

Parameters:
BYTES, 2, bytes per transaction; MSB byte (mdat[8*BYTES-1:8*BYTES-8]) is shifted first.
NSS, 2, number of slave-select outputs.
DIV, 2, SCLK half-period in clk cycles; must be >= 1.
SELW, 1, width of sel; must be >= max(1, clog2(NSS)).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  request a transaction; accepted only when busy=0
mdat  in  8*BYTES  data to send; sampled on the accepted start
sel  in  SELW  slave index; sampled on start
cpol  in  1  clock polarity; sampled on start
cpha  in  1  clock phase; sampled on start
abort  in  1  synchronous abort of the current transaction
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at completion
sdat  out  8*BYTES  data received; updated only at done
sclk  out  1  SPI clock
mosi  out  1  master out
miso  in  1  master in
ss_n  out  NSS  active-low slave selects

Behaviour:
- Reset values: busy=0, done=0, sdat=0, sclk=0, mosi=0, ss_n=all 1, state=IDLE. Reset asserted mid-transfer forces these values immediately.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - sclk follows the cpol input, registered.
  - start=1 and abort=0 latches mdat/sel/cpol/cpha and enters SETUP next cycle; busy=1 from that cycle.
- Timing, with start accepted at edge 0:
  - SETUP occupies DIV cycles; ss_n[sel]=0 from cycle 1.
  - SHIFT occupies 16*BYTES*DIV cycles. SCLK edges occur at 1+k*DIV for k=1..16*BYTES; odd k is the leading edge, even k the trailing edge.
  - HOLD occupies DIV cycles.
  - At cycle 1+DIV*(16*BYTES+2): ss_n returns to all 1, done=1 for one cycle, sdat takes the received word, GAP begins.
  - GAP occupies DIV cycles with busy=1; then IDLE and busy=0.
- Bit timing:
  - CPHA=0: the first mosi bit is valid on entry to SETUP. miso is sampled on the leading edge; mosi advances on the trailing edge.
  - CPHA=1: mosi advances on the leading edge (first bit appears there); miso is sampled on the trailing edge.
  - mosi holds its last bit through HOLD and returns to 0 in GAP.
- sclk idles at the latched cpol throughout the transaction and toggles only at the edges listed above.
- Received bits shift into an internal register, MSB first. sdat is a shadow copy, stable between done pulses.
- start while busy=1 is ignored; no queueing.
- abort=1 in any non-IDLE state forces IDLE next cycle: ss_n all 1, sclk=cpol, busy=0, no done pulse, sdat unchanged. abort and start in the same IDLE cycle: start is ignored.
- sel >= NSS: the transaction runs with full timing but asserts no ss_n bit; sdat still updates.

Optional Feature:
- SPI_MASTER_LSB_FIRST_EN defined: bits within each byte are sent and received LSB first. Byte order is unchanged (MSB byte first).
- Undefined: MSB first throughout.

Decomposition:
- Package spi_pkg holds the state enumeration (IDLE, SETUP, SHIFT, HOLD, GAP) and the mode constants MODE0..MODE3 as {cpol,cpha}.
- Sub-module spi_clkgen: a divide-by-DIV counter producing half-period tick strobes plus a leading/trailing flag. It is cleared by reset and by abort.

Test Plan:
- BYTES=2, DIV=2, mode 0, sel=0, mdat=16'habcd; slave returns 8'h78 then 8'ha1 -> mosi bytes ab,cd; sdat=16'h78a1; ss_n[0] low cycles 1..68; done at cycle 69; busy low at cycle 71.
- Back-to-back transactions: start asserted the cycle busy falls with mdat=16'h5070; slave returns b3,34 -> sdat=16'hb334; previous sdat held until the new done; start pulses while busy have no effect.
- All four modes with mdat=16'h5aa5 looped back (miso=mosi) -> sdat=16'h5aa5; sclk idle level equals cpol; edge count 32.
- Abort asserted at cycle 6 -> next cycle busy=0, ss_n=2'b11, no done, sdat unchanged. Async reset asserted mid-SHIFT -> all outputs at reset values immediately.
- NSS=2, sel=1 -> only ss_n[1] toggles. sel=1 with NSS=1, SELW=1 -> ss_n stays 1, done still pulses.
- SPI_MASTER_LSB_FIRST_EN defined, mdat=16'h0180 -> mosi bit stream 1000000000000001; loopback sdat=16'h0180.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: transaction state encoding and SPI mode constants {cpol,cpha}.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator for the SPI master; tick fires every DIV clk cycles while enabled,
// lead marks odd-numbered ticks (leading SCLK edges).
module spi_clkgen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic abort,
  output logic tick,
  output logic lead
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          ph;

  assign tick = en && (cnt == CW'(DIV - 1));
  assign lead = tick && !ph;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else if (abort || !en) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      ph  <= ~ph;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/spi_master_multi.sv
// Multi-byte SPI master with runtime CPOL/CPHA, divided SCLK, slave selects and abort.
// Optional build macro SPI_MASTER_LSB_FIRST_EN: bits within each byte travel LSB first.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int BYTES = 2,
  parameter int NSS   = 2,
  parameter int DIV   = 2,
  parameter int SELW  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8*BYTES-1:0] mdat,
  input  logic [SELW-1:0]    sel,
  input  logic               cpol,
  input  logic               cpha,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [8*BYTES-1:0] sdat,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic [NSS-1:0]     ss_n
);
  localparam int N     = 8 * BYTES;
  localparam int EDGES = 2 * N;
  localparam int EW    = $clog2(EDGES + 1);

  spi_state_e    state;
  logic          cpol_q, cpha_q;
  logic [N-1:0]  tx, rx, ord;
  logic [EW-1:0] ecnt;
  logic          tick, lead, accept, edge_now, sample, advance;

  // Maps between wire order (first bit at MSB) and word order; self-inverse.
  function automatic logic [N-1:0] bit_order(input logic [N-1:0] w);
    logic [N-1:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
    for (int b = 0; b < BYTES; b++)
      for (int i = 0; i < 8; i++)
        r[8*b+i] = w[8*b+7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  function automatic logic [NSS-1:0] decode(input logic [SELW-1:0] s);
    logic [NSS-1:0] r;
    for (int j = 0; j < NSS; j++) r[j] = (int'(s) != j);
    return r;
  endfunction

  assign ord      = bit_order(mdat);
  assign accept   = (state == IDLE) && start && !abort;
  assign edge_now = tick && !abort &&
                    ((state == SETUP) || ((state == SHIFT) && (ecnt != EW'(EDGES))));
  assign sample   = edge_now && (lead ^ cpha_q);
  // The final trailing edge in CPHA=0 has no further bit to present, so mosi holds.
  assign advance  = edge_now && (cpha_q ? lead : (!lead && (ecnt != EW'(EDGES - 1))));

  spi_clkgen #(.DIV(DIV)) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .abort (abort),
    .tick  (tick),
    .lead  (lead)
  );

  always_ff @(posedge clk) begin
    if (accept)       tx <= cpha ? ord : {ord[N-2:0], 1'b0};
    else if (advance) tx <= {tx[N-2:0], 1'b0};
    if (sample)       rx <= {rx[N-2:0], miso};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sdat   <= '0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      ss_n   <= '1;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      ecnt   <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
        ss_n  <= '1;
        sclk  <= cpol_q;
        mosi  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sclk <= cpol;
            if (accept) begin
              state  <= SETUP;
              busy   <= 1'b1;
              cpol_q <= cpol;
              cpha_q <= cpha;
              ss_n   <= decode(sel);
              ecnt   <= '0;
              mosi   <= cpha ? 1'b0 : ord[N-1];
            end
          end
          SETUP: if (tick) state <= SHIFT;
          SHIFT: if (tick && (ecnt == EW'(EDGES))) state <= HOLD;
          HOLD: if (tick) begin
            state <= GAP;
            done  <= 1'b1;
            ss_n  <= '1;
            sdat  <= bit_order(rx);
            mosi  <= 1'b0;
          end
          GAP: if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
        if (edge_now) begin
          sclk <= ~sclk;
          ecnt <= ecnt + EW'(1);
        end
        if (advance) mosi <= tx[N-1];
      end
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// Randomised and directed bench for spi_master_multi against a cycle-formula model of the protocol.
module tb_spi_master_multi;
  import spi_pkg::*;

  localparam int BYTES = 2, NSS = 2, DIV = 2, SELW = 1;
  localparam int N = 8 * BYTES, EDG = 2 * N;
  localparam int LDONE = DIV * (EDG + 2) + 1;
  localparam int ENDC  = DIV * (EDG + 3);

  logic clk = 1'b0, reset = 1'b0;
  logic start = 0, cpol = 0, cpha = 0, abort = 0, lpbk = 0, miso_s = 0;
  logic [15:0] mdat = '0, slv_word = '0;
  logic [SELW-1:0] sel = '0;
  logic busy, done, sclk, mosi, miso;
  logic [15:0] sdat;
  logic [NSS-1:0] ss_n;

  logic start1 = 0, sel1 = 0, busy1, done1, sclk1, mosi1;
  logic [7:0] mdat1 = '0, sdat1;
  logic [0:0] ss_n1;

  int n_vec = 0, n_err = 0;

  assign miso = lpbk ? mosi : miso_s;

  always #5 clk = ~clk;

  spi_master_multi #(.BYTES(BYTES), .NSS(NSS), .DIV(DIV), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .start(start), .mdat(mdat), .sel(sel), .cpol(cpol), .cpha(cpha),
    .abort(abort), .busy(busy), .done(done), .sdat(sdat), .sclk(sclk), .mosi(mosi), .miso(miso),
    .ss_n(ss_n));

  spi_master_multi #(.BYTES(1), .NSS(1), .DIV(1), .SELW(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mdat(mdat1), .sel(sel1), .cpol(1'b0), .cpha(1'b0),
    .abort(1'b0), .busy(busy1), .done(done1), .sdat(sdat1), .sclk(sclk1), .mosi(mosi1),
    .miso(mosi1), .ss_n(ss_n1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // i-th bit on the wire of a word: bytes MSB first, bits per build option.
  function automatic logic bitof(input logic [15:0] w, input int i);
    int b, p;
    b = i / 8;
`ifdef SPI_MASTER_LSB_FIRST_EN
    p = i % 8;
`else
    p = 7 - (i % 8);
`endif
    return w[8*(BYTES-1-b)+p];
  endfunction

  bit act = 0;
  int c = 0, m_sel = 0;
  logic m_cpol = 0, m_cpha = 0, e_sclk = 0;
  logic [15:0] m_mdat = '0, m_rx = '0, m_sdat = '0;

  always @(posedge clk) begin
    logic st, ab, cp_in, e_busy, e_done, e_mosi;
    logic [NSS-1:0] e_ss;
    int ne, bi;
    st = start; ab = abort; cp_in = cpol;
    if (!reset) begin
      act = 0; c = 0; m_sdat = '0; e_sclk = 1'b0;
    end else if (act) begin
      if (ab || c == ENDC) begin act = 0; e_sclk = m_cpol; end
      else c++;
    end else begin
      e_sclk = cp_in;
      if (st && !ab) begin
        act = 1; c = 1; m_mdat = mdat; m_sel = int'(sel); m_cpol = cpol; m_cpha = cpha;
        m_rx = lpbk ? mdat : slv_word;
      end
    end
    #1;
    e_busy = 0; e_done = 0; e_mosi = 0; e_ss = '1;
    if (act) begin
      e_busy = 1;
      e_done = (c == LDONE);
      if (c < LDONE && m_sel < NSS) e_ss[m_sel] = 1'b0;
      ne = (c < 1 + DIV) ? 0 : (((c - 1) / DIV > EDG) ? EDG : (c - 1) / DIV);
      e_sclk = m_cpol ^ ne[0];
      if (c < LDONE) begin
        if (!m_cpha) e_mosi = bitof(m_mdat, (ne / 2 > N - 1) ? N - 1 : ne / 2);
        else if (ne > 0) e_mosi = bitof(m_mdat, ((ne - 1) / 2 > N - 1) ? N - 1 : (ne - 1) / 2);
      end
      if (c == LDONE) m_sdat = m_rx;
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("ss_n", 32'(ss_n), 32'(e_ss));
    chk("sclk", 32'(sclk), 32'(e_sclk));
    chk("mosi", 32'(mosi), 32'(e_mosi));
    chk("sdat", 32'(sdat), 32'(m_sdat));
    // Slave presents the bit the master will sample at the next sampling tick.
    miso_s = 1'b0;
    if (act) begin
      bi = -1;
      for (int i = N - 1; i >= 0; i--)
        if ((2 * i + 1 + int'(m_cpha)) * DIV >= c) bi = i;
      if (bi >= 0) miso_s = bitof(m_rx, bi);
    end
  end

  int r_done, r_idle, r_ss, r_edges;
  logic [NSS-1:0] r_seen;
  logic [15:0] r_stream;
  logic r_idle_lvl;

  // Called at a negedge; drives start there and observes each following cycle until idle.
  task automatic xfer(input logic [15:0] md, input int sl, input logic [1:0] mode, input logic lp,
                      input logic [15:0] sw, input int abort_at, input bit poke);
    logic prev;
    int n;
    mdat = md; sel = SELW'(sl); cpol = mode[1]; cpha = mode[0]; lpbk = lp; slv_word = sw;
    start = 1'b1;
    r_done = 0; r_idle = 0; r_ss = 0; r_seen = '0; r_edges = 0; r_stream = '0;
    prev = mode[1];
    @(negedge clk);
    start = 1'b0;
    n = 1;
    r_idle_lvl = sclk;
    while (n < 2000) begin
      if (done) r_done = n;
      if (ss_n != '1) r_ss++;
      r_seen = r_seen | ~ss_n;
      if (sclk != prev) begin
        r_edges++;
        if ((sclk != mode[1]) ^ mode[0]) r_stream = {r_stream[14:0], mosi};
        prev = sclk;
      end
      if (!busy) begin r_idle = n; break; end
      abort = (n == abort_at);
      if (poke && (n == 10 || n == 40)) begin start = 1'b1; mdat = 16'($urandom); end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    abort = 1'b0; start = 1'b0;
    if (r_idle == 0) begin
      n_vec++; n_err++;
      $display("FAIL xfer_timeout busy=%0b after %0d cycles", busy, n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] modes [4];
    int d1;
    logic low1;
    modes[0] = MODE0; modes[1] = MODE1; modes[2] = MODE2; modes[3] = MODE3;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sdat", 32'(sdat), 0);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_ss_n", 32'(ss_n), 32'h3);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    xfer(16'habcd, 0, MODE0, 1'b0, 16'h78a1, 0, 0);
    chk("t1_done_cyc", r_done, 69);
    chk("t1_idle_cyc", r_idle, 71);
    chk("t1_ss_low", r_ss, 68);
    chk("t1_edges", r_edges, 32);
    chk("t1_sdat", 32'(sdat), 32'h78a1);
`ifdef SPI_MASTER_LSB_FIRST_EN
    chk("t1_stream", 32'(r_stream), 32'hd5b3);
`else
    chk("t1_stream", 32'(r_stream), 32'habcd);
`endif

    xfer(16'h5070, 0, MODE0, 1'b0, 16'hb334, 0, 1);
    chk("b2b_sdat", 32'(sdat), 32'hb334);
    chk("b2b_done_cyc", r_done, 69);

    xfer(16'hffff, 0, MODE0, 1'b0, 16'h0f0f, 6, 0);
    chk("abort_idle_cyc", r_idle, 7);
    chk("abort_no_done", r_done, 0);
    chk("abort_ss_n", 32'(ss_n), 32'h3);
    chk("abort_sdat", 32'(sdat), 32'hb334);

    for (int m = 0; m < 4; m++) begin
      repeat (2) @(negedge clk);
      xfer(16'h5aa5, 0, modes[m], 1'b1, 16'h0000, 0, 0);
      chk("mode_sdat", 32'(sdat), 32'h5aa5);
      chk("mode_edges", r_edges, 32);
      chk("mode_idle_lvl", 32'(r_idle_lvl), 32'(modes[m][1]));
      chk("mode_stream", 32'(r_stream), 32'h5aa5);
    end

    xfer(16'h1357, 1, MODE0, 1'b0, 16'h9bdf, 0, 0);
    chk("sel1_seen", 32'(r_seen), 32'h2);
    chk("sel1_sdat", 32'(sdat), 32'h9bdf);

    xfer(16'h0180, 0, MODE0, 1'b1, 16'h0000, 0, 0);
    chk("lsb_sdat", 32'(sdat), 32'h0180);
`ifdef SPI_MASTER_LSB_FIRST_EN
    chk("lsb_stream", 32'(r_stream), 32'h8001);
`else
    chk("lsb_stream", 32'(r_stream), 32'h0180);
`endif

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 0);

    mdat = 16'h1234; sel = '0; cpol = 1'b1; cpha = 1'b0; lpbk = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_sdat", 32'(sdat), 0);
    chk("arst_sclk", 32'(sclk), 0);
    chk("arst_mosi", 32'(mosi), 0);
    chk("arst_ss_n", 32'(ss_n), 32'h3);
    repeat (2) @(negedge clk);
    reset = 1'b1; cpol = 1'b0;
    @(negedge clk);

    mdat1 = 8'h3c; sel1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    d1 = 0; low1 = 1'b0;
    for (int n = 1; n < 200; n++) begin
      if (ss_n1 != 1'b1) low1 = 1'b1;
      if (done1) d1 = n;
      if (!busy1) break;
      @(negedge clk);
    end
    chk("nss1_done_cyc", d1, 19);
    chk("nss1_ss_low", 32'(low1), 0);
    chk("nss1_sdat", 32'(sdat1), 32'h3c);

    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 3)) begin
        cpol = 1'($urandom);
        @(negedge clk);
      end
      xfer(16'($urandom), $urandom_range(0, 1), 2'($urandom), 1'($urandom), 16'($urandom),
           ($urandom_range(0, 3) == 0) ? $urandom_range(2, 70) : 0, 1'($urandom));
    end
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
